// File: rtl/slot_merge_pkg.sv
// Shared constants and helpers for the four-lane I2S slot merger.
// Lane n carries output channels 2n (left) and 2n+1 (right).
package slot_merge_pkg;

  localparam int num_lanes       = 4;
  localparam int words_per_lane  = 2;
  localparam int chans_per_frame = 8;
  localparam int chan_idx_w      = $clog2(chans_per_frame);
  localparam int lane_idx_w      = $clog2(num_lanes);

  typedef logic [chan_idx_w-1:0] chan_t;
  typedef logic [lane_idx_w-1:0] lane_idx_t;

  // Source lane of a given output channel.
  function automatic lane_idx_t lane_of(input chan_t chan);
    return lane_idx_t'(chan / words_per_lane);
  endfunction

endpackage

// File: rtl/fifo_interface.sv
// Word stream bundle: a transfer happens in a cycle where enable=1 and ready=1.
interface FIFOInterface #(
  parameter int data_width = 32
) ();

  logic                  enable;
  logic                  ready;
  logic [data_width-1:0] data;

  modport in  (input enable, input data, output ready);
  modport out (output enable, output data, input ready);

endinterface

// File: rtl/sample_lane_fifo.sv
// Per-lane sample buffer. ready depends only on reset and the registered
// count, so it never sees the downstream ready.
module sample_lane_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic                  ready,
  output logic [data_width-1:0] head,
  output logic                  empty,
  output logic                  overflow
);

  localparam int addr_w = $clog2(depth);
  localparam int cnt_w  = addr_w + 1;

  logic [data_width-1:0] mem [depth];
  logic [addr_w-1:0]     wr_ptr;
  logic [addr_w-1:0]     rd_ptr;
  logic [cnt_w-1:0]      count;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == cnt_w'(depth));
  assign empty   = (count == '0);
  assign ready   = !reset && !full;
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + addr_w'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + addr_w'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
      if (push && !ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/slot_sample_merger.sv
// Merges four stereo I2S lanes into one ordered 8-channel stream.
// The sequencer waits on an empty lane rather than skip a channel.
module slot_sample_merger
  import slot_merge_pkg::*;
#(
  parameter int data_width = 32,
  parameter int lane_depth = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  FIFOInterface.in              lane_a,
  FIFOInterface.in              lane_b,
  FIFOInterface.in              lane_c,
  FIFOInterface.in              lane_d,
  FIFOInterface.out             samples,
  output logic [chan_idx_w-1:0] chan_idx,
  output logic                  frame_start,
  output logic [num_lanes-1:0]  overflow
);

  logic [num_lanes-1:0]  lane_en;
  logic [num_lanes-1:0]  lane_rdy;
  logic [num_lanes-1:0]  lane_empty;
  logic [num_lanes-1:0]  lane_pop;
  logic [data_width-1:0] lane_dat  [num_lanes];
  logic [data_width-1:0] lane_head [num_lanes];

  assign lane_en     = {lane_d.enable, lane_c.enable, lane_b.enable, lane_a.enable};
  assign lane_dat[0] = lane_a.data;
  assign lane_dat[1] = lane_b.data;
  assign lane_dat[2] = lane_c.data;
  assign lane_dat[3] = lane_d.data;

  assign lane_a.ready = lane_rdy[0];
  assign lane_b.ready = lane_rdy[1];
  assign lane_c.ready = lane_rdy[2];
  assign lane_d.ready = lane_rdy[3];

  for (genvar i = 0; i < num_lanes; i++) begin : g_lane
    sample_lane_fifo #(
      .data_width (data_width),
      .depth      (lane_depth)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (lane_en[i]),
      .push_data (lane_dat[i]),
      .pop       (lane_pop[i]),
      .ready     (lane_rdy[i]),
      .head      (lane_head[i]),
      .empty     (lane_empty[i]),
      .overflow  (overflow[i])
    );
  end

  chan_t                 ptr;
  lane_idx_t             sel;
  logic                  out_valid;
  logic [data_width-1:0] out_data;
  logic                  drain;
  logic                  load;

  assign sel   = lane_of(ptr);
  assign drain = out_valid && samples.ready;
  // Load when the selected lane has a word and the register is free this cycle.
  assign load  = !lane_empty[sel] && (!out_valid || samples.ready);

  always_comb begin
    lane_pop      = '0;
    lane_pop[sel] = load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      chan_idx    <= '0;
      frame_start <= 1'b0;
    end else if (load) begin
      ptr         <= ptr + chan_idx_w'(1);
      out_valid   <= 1'b1;
      out_data    <= lane_head[sel];
      chan_idx    <= ptr;
      frame_start <= (ptr == '0);
    end else if (drain) begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign samples.enable = out_valid;
  assign samples.data   = out_data;

endmodule

// File: tb/tb_slot_sample_merger.sv
// Directed and random checks of slot_sample_merger against an ordered
// interleave model fed from the observed lane transfers.
module tb_slot_sample_merger;

  logic        clk;
  logic        reset;
  logic [3:0]  lane_en;
  logic [31:0] lane_dat [4];
  logic [3:0]  lane_rdy;
  logic        out_rdy;
  logic [2:0]  chan_idx;
  logic        frame_start;
  logic [3:0]  overflow;

  FIFOInterface #(.data_width(32)) lane_a_if ();
  FIFOInterface #(.data_width(32)) lane_b_if ();
  FIFOInterface #(.data_width(32)) lane_c_if ();
  FIFOInterface #(.data_width(32)) lane_d_if ();
  FIFOInterface #(.data_width(32)) samples_if ();

  assign lane_a_if.enable = lane_en[0];
  assign lane_b_if.enable = lane_en[1];
  assign lane_c_if.enable = lane_en[2];
  assign lane_d_if.enable = lane_en[3];
  assign lane_a_if.data   = lane_dat[0];
  assign lane_b_if.data   = lane_dat[1];
  assign lane_c_if.data   = lane_dat[2];
  assign lane_d_if.data   = lane_dat[3];
  assign lane_rdy = {lane_d_if.ready, lane_c_if.ready, lane_b_if.ready, lane_a_if.ready};
  assign samples_if.ready = out_rdy;

  slot_sample_merger #(.data_width(32), .lane_depth(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .lane_a      (lane_a_if),
    .lane_b      (lane_b_if),
    .lane_c      (lane_c_if),
    .lane_d      (lane_d_if),
    .samples     (samples_if),
    .chan_idx    (chan_idx),
    .frame_start (frame_start),
    .overflow    (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  int          out_count = 0;
  logic [31:0] lane_q [4][$];
  logic [34:0] exp_q [$];
  logic [2:0]  m_ptr = 3'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record accepted lane words, build the channel-ordered expectation,
  // and compare each output transfer against it.
  always @(negedge clk) begin
    logic [34:0] e;
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l] && lane_rdy[l]) lane_q[l].push_back(lane_dat[l]);
      end
      while (lane_q[m_ptr[2:1]].size() > 0) begin
        exp_q.push_back({m_ptr, lane_q[m_ptr[2:1]].pop_front()});
        m_ptr = m_ptr + 3'd1;
      end
      if (samples_if.enable && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", samples_if.data, e[31:0]);
          check("out_chan", chan_idx, e[34:32]);
          check("out_frame", frame_start, e[34:32] == 3'd0);
        end
        out_count++;
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic clear_model();
    for (int l = 0; l < 4; l++) lane_q[l].delete();
    exp_q.delete();
    m_ptr = 3'd0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    lane_en = 4'h0;
    clear_model();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_frame(input logic [3:0] mask, input logic [31:0] base);
    for (int w = 0; w < 2; w++) begin
      for (int l = 0; l < 4; l++) begin
        lane_en[l]  = mask[l];
        lane_dat[l] = base + 32'(l * 16) + 32'(w);
      end
      @(posedge clk); #1;
    end
    lane_en = 4'h0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || samples_if.enable) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n >= budget, 0);
  endtask

  task automatic wait_count(input string tag, input int target, input int budget);
    int n = 0;
    while (out_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n >= budget, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    int remaining [4];
    reset   = 1'b1;
    lane_en = 4'h0;
    out_rdy = 1'b1;
    for (int l = 0; l < 4; l++) lane_dat[l] = '0;

    // reset state and lane ready release
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk); #1;
    check("rst_enable", samples_if.enable, 0);
    check("rst_data", samples_if.data, 0);
    check("rst_chan", chan_idx, 0);
    check("rst_frame", frame_start, 0);
    check("rst_overflow", overflow, 0);
    check("rst_lane_ready", lane_rdy, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("post_rst_lane_ready", lane_rdy, 4'hF);
    @(posedge clk); #1;

    // basic frame, latency and throughput
    for (int l = 0; l < 4; l++) begin
      lane_en[l] = 1'b1; lane_dat[l] = 32'hA0 + 32'(l * 16);
    end
    @(posedge clk); #1;
    for (int l = 0; l < 4; l++) lane_dat[l] = 32'hA1 + 32'(l * 16);
    @(negedge clk); #1;
    check("lat_not_yet", samples_if.enable, 0);
    @(posedge clk); #1;
    lane_en = 4'h0;
    @(negedge clk); #1;
    check("lat_enable", samples_if.enable, 1);
    check("lat_data", samples_if.data, 32'hA0);
    check("lat_frame", frame_start, 1);
    c0 = out_count;
    repeat (7) @(negedge clk);
    #1;
    check("throughput", out_count - c0, 7);
    @(posedge clk); #1;
    wait_drain("frame1_drain", 50);

    // lane_c withheld
    c0 = out_count;
    push_frame(4'b1011, 32'h30);
    repeat (20) @(posedge clk);
    #1;
    check("stall_c_count", out_count - c0, 4);
    check("stall_c_enable", samples_if.enable, 0);
    push_frame(4'b0100, 32'h30);
    wait_drain("stall_c_drain", 50);
    check("stall_c_total", out_count - c0, 8);

    // output backpressure holds the register stable
    out_rdy = 1'b0;
    c0 = out_count;
    push_frame(4'hF, 32'hE0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("hold_enable", samples_if.enable, 1);
      check("hold_data", samples_if.data, 32'hE0);
      check("hold_chan", chan_idx, 0);
      check("hold_frame", frame_start, 1);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    wait_drain("hold_drain", 50);
    check("hold_total", out_count - c0, 8);

    // lane_b overflow while the output is stalled on empty lane_a
    out_rdy = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      lane_en[1] = 1'b1; lane_dat[1] = 32'h50 + 32'(k);
      @(posedge clk); #1;
      lane_en[1] = 1'b0;
      @(negedge clk); #1;
      check("ovf_lane_b_ready", lane_rdy[1], k < 8);
      check("ovf_flags", overflow, (k == 9) ? 4'b0010 : 4'b0000);
      @(posedge clk); #1;
    end
    check("ovf_other_ready", {lane_rdy[3:2], lane_rdy[0]}, 3'b111);
    apply_reset(1);
    @(negedge clk); #1;
    check("ovf_cleared", overflow, 0);
    @(posedge clk); #1;

    // reset mid-frame after ch3
    out_rdy = 1'b1;
    c0 = out_count;
    push_frame(4'b0011, 32'h70);
    wait_count("mid_ch3_wait", c0 + 4, 50);
    out_rdy = 1'b0;
    push_frame(4'b1100, 32'h80);
    repeat (3) @(posedge clk);
    #1;
    check("mid_held_chan", chan_idx, 4);
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("mid_rst_enable", samples_if.enable, 0);
    check("mid_rst_data", samples_if.data, 0);
    check("mid_rst_chan", chan_idx, 0);
    check("mid_rst_frame", frame_start, 0);
    check("mid_rst_overflow", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_rdy = 1'b1;
    push_frame(4'hF, 32'h100);
    n = 0;
    while (!samples_if.enable && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_refill_timeout", n >= 20, 0);
    check("mid_first_chan", chan_idx, 0);
    check("mid_first_data", samples_if.data, 32'h100);
    wait_drain("mid_drain", 50);

    // 1000 random frames with random stalls
    c0 = out_count;
    for (int l = 0; l < 4; l++) remaining[l] = 2000;
    n = 0;
    while ((remaining[0] + remaining[1] + remaining[2] + remaining[3]) > 0 && n < 60000) begin
      for (int l = 0; l < 4; l++) begin
        if (remaining[l] > 0 && lane_rdy[l] && $urandom_range(0, 3) != 0) begin
          lane_en[l]  = 1'b1;
          lane_dat[l] = $urandom;
          remaining[l]--;
        end else begin
          lane_en[l] = 1'b0;
        end
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    lane_en = 4'h0;
    out_rdy = 1'b1;
    check("rand_timeout", n >= 60000, 0);
    wait_drain("rand_drain", 200);
    check("rand_total", out_count - c0, 8000);
    check("rand_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
